line_mem_ctrl: RTL

Main-memory line controller sitting directly downstream of cache_controller. It consumes the controller's mem_read/mem_write line requests (128-bit lines, 32-bit byte address) and performs them against an internal line array after a fixed, parameterised latency. It returns m_r_data plus a single-cycle main_mem_ack, and replaces the bare behavioural memory model with a deterministic, handshake-checked stage.

---
 rtl/line_mem_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/line_mem_ctrl.sv
// Main-memory line controller: serves one cache-line read or write per
// handshake against an internal line array after a fixed latency, then
// pulses main_mem_ack and waits for the requester to drop its request.
module line_mem_ctrl #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LINE_W  = 128,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [LINE_W-1:0] m_w_data,
    output logic [LINE_W-1:0] m_r_data,
    output logic              main_mem_ack,
    output logic              busy,
    output logic              req_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(LATENCY + 1);
    localparam int unsigned WORDS = LINE_W / 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ACK   = 2'd2,
        DRAIN = 2'd3
    } state_e;

    // Power-up content of a line: every 32-bit word holds its own byte address.
    function automatic logic [LINE_W-1:0] init_line(input logic [IDX_W-1:0] idx);
        logic [LINE_W-1:0] line;
        line = '0;
        for (int j = 0; j < int'(WORDS); j++) begin
            line[32*j +: 32] = 32'({idx, 4'b0000}) | 32'(j << 2);
        end
        return line;
    endfunction

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                wr_q, wr_d;
    logic [LINE_W-1:0]   data_q, data_d;
    logic [LINE_W-1:0]   rdata_q, rdata_d;
    logic                ack_q, ack_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;

    // Line storage plus a per-line "overwritten" flag; untouched lines read
    // their power-up pattern, so no bulk initialisation of the array is needed.
    logic [LINE_W-1:0]   mem_q [DEPTH];
    logic [DEPTH-1:0]    written_q = '0;

    logic                req_c;
    logic                mem_op_c;
    logic [IDX_W-1:0]    addr_idx_c;
    logic [LINE_W-1:0]   rd_line_c;
    logic                unused_addr_c;

    assign req_c         = mem_read | mem_write;
    assign addr_idx_c    = m_addr[IDX_W+3:4];
    assign unused_addr_c = ^{m_addr[ADDR_W-1:IDX_W+4], m_addr[3:0]};
    assign rd_line_c     = written_q[idx_q] ? mem_q[idx_q] : init_line(idx_q);

    // Next-state, latching of the request fields and registered output values.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        wr_d     = wr_q;
        data_d   = data_q;
        rdata_d  = rdata_q;
        err_d    = 1'b0;
        mem_op_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_c) begin
                    idx_d   = addr_idx_c;
                    wr_d    = mem_write;
                    data_d  = m_w_data;
                    err_d   = mem_read & mem_write;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    mem_op_c = 1'b1;
                    state_d  = ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACK: begin
                state_d = req_c ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (!req_c) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (mem_op_c && !wr_q) begin
            rdata_d = rd_line_c;
        end
        ack_d  = (state_d == ACK);
        busy_d = (state_d != IDLE);
    end

    // Control and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            data_q  <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Array write on the ACK entry edge; the array is not reset.
    always_ff @(posedge clk) begin
        if (mem_op_c && wr_q && !rst) begin
            mem_q[idx_q]     <= data_q;
            written_q[idx_q] <= 1'b1;
        end
    end

    assign m_r_data     = rdata_q;
    assign main_mem_ack = ack_q;
    assign busy         = busy_q;
    assign req_err      = err_q;

endmodule
